// File: rtl/dallanma_paket.sv
// rtl/dallanma_paket.sv - shared constants, queue entry layout and FSM encodings for branch resolution
package dallanma_paket;

    // RISC-V control-transfer opcodes
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    // FSM state encodings
    localparam logic [0:0] CALIS   = 1'b0;
    localparam logic [0:0] TOPARLA = 1'b1;

    // One in-flight branch: PC, instruction word, predicted direction, predicted target
    typedef struct packed {
        logic [31:0] adres;
        logic [31:0] buyruk;
        logic        ongoru;
        logic [31:0] hedef;
    } kuyruk_girdisi_t;

    localparam int GIRDI_GENISLIK = $bits(kuyruk_girdisi_t);

    // Fall-through PC of a not-taken branch, wrapping modulo 2^32
    function automatic logic [31:0] sonraki_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/dallanma_kuyrugu.sv
// rtl/dallanma_kuyrugu.sv - synchronous in-flight branch FIFO with single-cycle flush
module dallanma_kuyrugu #(
    parameter int DERINLIK = 4,
    parameter int GENISLIK = 97
) (
    input  logic                i_saat,
    input  logic                i_reset,
    input  logic                i_temizle,
    input  logic                i_yaz,
    input  logic [GENISLIK-1:0] i_veri,
    input  logic                i_oku,
    output logic [GENISLIK-1:0] o_veri,
    output logic                o_dolu,
    output logic                o_bos
);

    localparam int AW = $clog2(DERINLIK);
    localparam logic [AW:0] BIR = {{AW{1'b0}}, 1'b1};

    logic [AW:0]         yaz_ptr_q, yaz_ptr_d;
    logic [AW:0]         oku_ptr_q, oku_ptr_d;
    logic [GENISLIK-1:0] bellek_q [DERINLIK];

    // Extra pointer MSB distinguishes full from empty when the index bits match
    assign o_bos  = (yaz_ptr_q == oku_ptr_q);
    assign o_dolu = (yaz_ptr_q[AW] != oku_ptr_q[AW]) && (yaz_ptr_q[AW-1:0] == oku_ptr_q[AW-1:0]);
    assign o_veri = bellek_q[oku_ptr_q[AW-1:0]];

    // Next pointers: flush wins over any push or pop in the same cycle
    always_comb begin
        yaz_ptr_d = yaz_ptr_q;
        oku_ptr_d = oku_ptr_q;
        if (i_temizle) begin
            yaz_ptr_d = '0;
            oku_ptr_d = '0;
        end else begin
            if (i_yaz && !o_dolu) yaz_ptr_d = yaz_ptr_q + BIR;
            if (i_oku && !o_bos)  oku_ptr_d = oku_ptr_q + BIR;
        end
    end

    // Pointer registers
    always_ff @(posedge i_saat or posedge i_reset) begin
        if (i_reset) begin
            yaz_ptr_q <= '0;
            oku_ptr_q <= '0;
        end else begin
            yaz_ptr_q <= yaz_ptr_d;
            oku_ptr_q <= oku_ptr_d;
        end
    end

    // Entry storage; contents are only meaningful between the pointers, so no reset
    always_ff @(posedge i_saat) begin
        if (i_yaz && !o_dolu && !i_temizle) bellek_q[yaz_ptr_q[AW-1:0]] <= i_veri;
    end

endmodule

// File: rtl/dallanma_cozum_birimi.sv
// rtl/dallanma_cozum_birimi.sv - branch resolution, predictor training and redirect; option DALLANMA_SAYAC_EN adds resolve/mispredict counters
module dallanma_cozum_birimi
    import dallanma_paket::*;
#(
    parameter int DERINLIK       = 4,
    parameter int TOPARLA_CEVRIM = 2
) (
    input  logic        i_saat,
    input  logic        i_reset,
    input  logic        i_ekle,
    input  logic [31:0] i_buyruk_adresi,
    input  logic [31:0] i_buyruk,
    input  logic        i_buyruk_ongoru,
    input  logic [31:0] i_ongoru_adresi,
    output logic        o_hazir,
    input  logic        i_coz,
    input  logic        i_gercek_atladi,
    input  logic [31:0] i_gercek_adres,
    input  logic        i_temizle,
    output logic        o_guncelle,
    output logic [31:0] o_eski_buyruk,
    output logic [31:0] o_eski_buyruk_adresi,
    output logic        o_buyruk_atladi,
    output logic [31:0] o_atlanan_adres,
    output logic        o_ongoru_yanlis,
    output logic        o_yonlendir,
    output logic [31:0] o_yonlendirme_adresi,
    output logic        o_kuyruk_bos,
    output logic        o_hata
`ifdef DALLANMA_SAYAC_EN
    ,
    output logic [31:0] o_cozulen_sayisi,
    output logic [31:0] o_yanlis_sayisi
`endif
);

    localparam int SW = (TOPARLA_CEVRIM > 1) ? $clog2(TOPARLA_CEVRIM) : 1;

    kuyruk_girdisi_t yeni_girdi, bas;
    logic            kuyruk_dolu, kuyruk_bos;
    logic            cozum_gecerli, yanlis, yanlis_coz, yaz, kuyruk_temizle;

    logic [0:0]  durum_q, durum_d;
    logic [SW-1:0] sayac_q, sayac_d;
    logic        guncelle_q, guncelle_d, yanlis_q, yanlis_d, yonlendir_q, yonlendir_d;
    logic        atladi_q, atladi_d, hata_q, hata_d;
    logic [31:0] eski_buyruk_q, eski_buyruk_d, eski_adres_q, eski_adres_d;
    logic [31:0] atlanan_q, atlanan_d, yon_adres_q, yon_adres_d;

    assign yeni_girdi.adres  = i_buyruk_adresi;
    assign yeni_girdi.buyruk = i_buyruk;
    assign yeni_girdi.ongoru = i_buyruk_ongoru;
    assign yeni_girdi.hedef  = i_ongoru_adresi;

    // Fullness is taken before this cycle's pop, so a resolve never frees a slot for a same-cycle push
    assign o_hazir        = (durum_q == CALIS) && !kuyruk_dolu && !i_temizle;
    assign cozum_gecerli  = i_coz && !kuyruk_bos && !i_temizle;
    assign yanlis         = (i_gercek_atladi != bas.ongoru) ||
                            (i_gercek_atladi && bas.ongoru && (i_gercek_adres != bas.hedef));
    assign yanlis_coz     = cozum_gecerli && yanlis;
    assign yaz            = i_ekle && o_hazir && !yanlis_coz;
    assign kuyruk_temizle = i_temizle || yanlis_coz;

    dallanma_kuyrugu #(
        .DERINLIK (DERINLIK),
        .GENISLIK (GIRDI_GENISLIK)
    ) u_kuyruk (
        .i_saat    (i_saat),
        .i_reset   (i_reset),
        .i_temizle (kuyruk_temizle),
        .i_yaz     (yaz),
        .i_veri    (yeni_girdi),
        .i_oku     (cozum_gecerli),
        .o_veri    (bas),
        .o_dolu    (kuyruk_dolu),
        .o_bos     (kuyruk_bos)
    );

    // Recovery FSM and the registered training/redirect outputs
    always_comb begin
        durum_d       = durum_q;
        sayac_d       = sayac_q;
        guncelle_d    = cozum_gecerli;
        yanlis_d      = yanlis_coz;
        yonlendir_d   = yanlis_coz;
        atladi_d      = atladi_q;
        eski_buyruk_d = eski_buyruk_q;
        eski_adres_d  = eski_adres_q;
        atlanan_d     = atlanan_q;
        yon_adres_d   = yon_adres_q;
        hata_d        = hata_q | (i_coz && kuyruk_bos && !i_temizle);
        if (cozum_gecerli) begin
            eski_buyruk_d = bas.buyruk;
            eski_adres_d  = bas.adres;
            atladi_d      = i_gercek_atladi;
            atlanan_d     = i_gercek_adres;
        end
        if (yanlis_coz) begin
            yon_adres_d = i_gercek_atladi ? i_gercek_adres : sonraki_pc(bas.adres);
        end
        if (i_temizle) begin
            durum_d = CALIS;
            sayac_d = '0;
        end else if (yanlis_coz) begin
            durum_d = TOPARLA;
            sayac_d = SW'(TOPARLA_CEVRIM - 1);
        end else if (durum_q == TOPARLA) begin
            if (sayac_q == '0) durum_d = CALIS;
            else               sayac_d = sayac_q - 1'b1;
        end
    end

    // State registers
    always_ff @(posedge i_saat or posedge i_reset) begin
        if (i_reset) begin
            durum_q       <= CALIS;
            sayac_q       <= '0;
            guncelle_q    <= 1'b0;
            yanlis_q      <= 1'b0;
            yonlendir_q   <= 1'b0;
            atladi_q      <= 1'b0;
            hata_q        <= 1'b0;
            eski_buyruk_q <= '0;
            eski_adres_q  <= '0;
            atlanan_q     <= '0;
            yon_adres_q   <= '0;
        end else begin
            durum_q       <= durum_d;
            sayac_q       <= sayac_d;
            guncelle_q    <= guncelle_d;
            yanlis_q      <= yanlis_d;
            yonlendir_q   <= yonlendir_d;
            atladi_q      <= atladi_d;
            hata_q        <= hata_d;
            eski_buyruk_q <= eski_buyruk_d;
            eski_adres_q  <= eski_adres_d;
            atlanan_q     <= atlanan_d;
            yon_adres_q   <= yon_adres_d;
        end
    end

    assign o_guncelle           = guncelle_q;
    assign o_ongoru_yanlis      = yanlis_q;
    assign o_yonlendir          = yonlendir_q;
    assign o_eski_buyruk        = eski_buyruk_q;
    assign o_eski_buyruk_adresi = eski_adres_q;
    assign o_buyruk_atladi      = atladi_q;
    assign o_atlanan_adres      = atlanan_q;
    assign o_yonlendirme_adresi = yon_adres_q;
    assign o_kuyruk_bos         = kuyruk_bos;
    assign o_hata               = hata_q;

`ifdef DALLANMA_SAYAC_EN
    logic [31:0] cozulen_q, cozulen_d, yanlis_say_q, yanlis_say_d;

    // Statistics counters follow the registered training pulse
    always_comb begin
        cozulen_d    = cozulen_q + {31'd0, guncelle_q};
        yanlis_say_d = yanlis_say_q + {31'd0, guncelle_q && yanlis_q};
    end

    // Counter registers, wrapping at 2^32
    always_ff @(posedge i_saat or posedge i_reset) begin
        if (i_reset) begin
            cozulen_q    <= '0;
            yanlis_say_q <= '0;
        end else begin
            cozulen_q    <= cozulen_d;
            yanlis_say_q <= yanlis_say_d;
        end
    end

    assign o_cozulen_sayisi = cozulen_q;
    assign o_yanlis_sayisi  = yanlis_say_q;
`endif

endmodule

// File: tb/tb_dallanma_cozum_birimi.sv
// tb/tb_dallanma_cozum_birimi.sv - self-checking bench for dallanma_cozum_birimi
module tb_dallanma_cozum_birimi;

    localparam int D  = 4;
    localparam int TC = 2;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_ekle = 1'b0, i_buyruk_ongoru = 1'b0, i_coz = 1'b0, i_gercek_atladi = 1'b0, i_temizle = 1'b0;
    logic [31:0] i_buyruk_adresi = '0, i_buyruk = '0, i_ongoru_adresi = '0, i_gercek_adres = '0;
    logic        o_hazir, o_guncelle, o_buyruk_atladi, o_ongoru_yanlis, o_yonlendir, o_kuyruk_bos, o_hata;
    logic [31:0] o_eski_buyruk, o_eski_buyruk_adresi, o_atlanan_adres, o_yonlendirme_adresi;
`ifdef DALLANMA_SAYAC_EN
    logic [31:0] o_cozulen_sayisi, o_yanlis_sayisi;
`endif

    always #5 clk = ~clk;

    dallanma_cozum_birimi #(.DERINLIK(D), .TOPARLA_CEVRIM(TC)) dut (
        .i_saat(clk), .i_reset(i_reset), .i_ekle(i_ekle),
        .i_buyruk_adresi(i_buyruk_adresi), .i_buyruk(i_buyruk),
        .i_buyruk_ongoru(i_buyruk_ongoru), .i_ongoru_adresi(i_ongoru_adresi),
        .o_hazir(o_hazir), .i_coz(i_coz), .i_gercek_atladi(i_gercek_atladi),
        .i_gercek_adres(i_gercek_adres), .i_temizle(i_temizle),
        .o_guncelle(o_guncelle), .o_eski_buyruk(o_eski_buyruk),
        .o_eski_buyruk_adresi(o_eski_buyruk_adresi), .o_buyruk_atladi(o_buyruk_atladi),
        .o_atlanan_adres(o_atlanan_adres), .o_ongoru_yanlis(o_ongoru_yanlis),
        .o_yonlendir(o_yonlendir), .o_yonlendirme_adresi(o_yonlendirme_adresi),
        .o_kuyruk_bos(o_kuyruk_bos), .o_hata(o_hata)
`ifdef DALLANMA_SAYAC_EN
        , .o_cozulen_sayisi(o_cozulen_sayisi), .o_yanlis_sayisi(o_yanlis_sayisi)
`endif
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        tot_cnt++;
        if (gercek === beklenen) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", ad, gercek, beklenen, $time);
    endtask

    // Behavioural model: an ordered list of in-flight branches plus a recovery countdown
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        pred;
        logic [31:0] tgt;
    } girdi_t;

    girdi_t      m_q[$];
    int          m_rec = 0;
    logic        m_guncelle = 0, m_yanlis = 0, m_yon = 0, m_atladi = 0, m_hata = 0;
    logic [31:0] m_ins = 0, m_pc = 0, m_atlanan = 0, m_yon_adr = 0;
    logic [31:0] m_cozulen = 0, m_yanlis_say = 0;

    always @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            m_q.delete();
            m_rec = 0; m_guncelle = 0; m_yanlis = 0; m_yon = 0; m_atladi = 0; m_hata = 0;
            m_ins = 0; m_pc = 0; m_atlanan = 0; m_yon_adr = 0; m_cozulen = 0; m_yanlis_say = 0;
        end else begin
            bit     kabul, yanlis;
            girdi_t e;
            if (m_guncelle) m_cozulen++;
            if (m_guncelle && m_yanlis) m_yanlis_say++;
            kabul  = (m_rec == 0) && (m_q.size() < D) && !i_temizle;
            yanlis = 0;
            m_guncelle = 0; m_yanlis = 0; m_yon = 0;
            if (m_rec > 0) m_rec--;
            if (i_temizle) begin
                m_q.delete();
                m_rec = 0;
            end else begin
                if (i_coz) begin
                    if (m_q.size() == 0) m_hata = 1;
                    else begin
                        e = m_q.pop_front();
                        yanlis = (i_gercek_atladi != e.pred) ||
                                 (i_gercek_atladi && e.pred && i_gercek_adres != e.tgt);
                        m_guncelle = 1; m_yanlis = yanlis;
                        m_ins = e.ins; m_pc = e.pc;
                        m_atladi = i_gercek_atladi; m_atlanan = i_gercek_adres;
                        if (yanlis) begin
                            m_yon = 1;
                            m_yon_adr = i_gercek_atladi ? i_gercek_adres : e.pc + 32'd4;
                            m_q.delete();
                            m_rec = TC;
                        end
                    end
                end
                if (i_ekle && kabul && !yanlis)
                    m_q.push_back('{i_buyruk_adresi, i_buyruk, i_buyruk_ongoru, i_ongoru_adresi});
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("hazir", {31'd0, o_hazir}, {31'd0, (m_rec == 0) && (m_q.size() < D) && !i_temizle});
        chk("guncelle", {31'd0, o_guncelle}, {31'd0, m_guncelle});
        chk("ongoru_yanlis", {31'd0, o_ongoru_yanlis}, {31'd0, m_yanlis});
        chk("yonlendir", {31'd0, o_yonlendir}, {31'd0, m_yon});
        chk("kuyruk_bos", {31'd0, o_kuyruk_bos}, {31'd0, m_q.size() == 0});
        chk("hata", {31'd0, o_hata}, {31'd0, m_hata});
        chk("eski_buyruk", o_eski_buyruk, m_ins);
        chk("eski_adres", o_eski_buyruk_adresi, m_pc);
        chk("buyruk_atladi", {31'd0, o_buyruk_atladi}, {31'd0, m_atladi});
        chk("atlanan_adres", o_atlanan_adres, m_atlanan);
        chk("yonlendirme_adresi", o_yonlendirme_adresi, m_yon_adr);
`ifdef DALLANMA_SAYAC_EN
        chk("cozulen_sayisi", o_cozulen_sayisi, m_cozulen);
        chk("yanlis_sayisi", o_yanlis_sayisi, m_yanlis_say);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ekle(input logic [31:0] pc, input logic [31:0] ins, input logic p, input logic [31:0] t);
        i_ekle = 1; i_buyruk_adresi = pc; i_buyruk = ins; i_buyruk_ongoru = p; i_ongoru_adresi = t;
        tick();
        i_ekle = 0;
    endtask

    task automatic coz(input logic a, input logic [31:0] adr);
        i_coz = 1; i_gercek_atladi = a; i_gercek_adres = adr;
        tick();
        i_coz = 0;
    endtask

    initial begin
        repeat (2) tick();
        i_reset = 0;
        #1;
        chk("reset_hazir", {31'd0, o_hazir}, 32'd1);
        chk("reset_bos", {31'd0, o_kuyruk_bos}, 32'd1);
        chk("reset_guncelle", {31'd0, o_guncelle}, 32'd0);
        tick();

        // Correct prediction
        ekle(32'h100, 32'h00B50463, 1, 32'h200);
        coz(1, 32'h200);
        chk("s1_guncelle", {31'd0, o_guncelle}, 32'd1);
        chk("s1_yanlis", {31'd0, o_ongoru_yanlis}, 32'd0);
        chk("s1_yonlendir", {31'd0, o_yonlendir}, 32'd0);
        chk("s1_bos", {31'd0, o_kuyruk_bos}, 32'd1);
        tick();

        // Direction mispredict flushes the younger entry and stalls for the recovery window
        ekle(32'h100, 32'h00B50463, 1, 32'h200);
        ekle(32'h140, 32'h00C60663, 0, 32'h180);
        coz(0, 32'h0);
        chk("s2_yanlis", {31'd0, o_ongoru_yanlis}, 32'd1);
        chk("s2_yonlendir", {31'd0, o_yonlendir}, 32'd1);
        chk("s2_adres", o_yonlendirme_adresi, 32'h104);
        chk("s2_hazir0", {31'd0, o_hazir}, 32'd0);
        chk("s2_bos", {31'd0, o_kuyruk_bos}, 32'd1);
        ekle(32'h300, 32'h0, 0, 32'h0);
        chk("s2_hazir1", {31'd0, o_hazir}, 32'd0);
        chk("s2_yonlendir_pulse", {31'd0, o_yonlendir}, 32'd0);
        tick();
        chk("s2_hazir_geri", {31'd0, o_hazir}, 32'd1);

        // Fall-through address wraps past 2^32
        ekle(32'hFFFFFFFC, 32'h00000063, 1, 32'h80);
        coz(0, 32'h0);
        chk("s3_adres", o_yonlendirme_adresi, 32'h0);
        repeat (2) tick();

        // Full queue with simultaneous resolve still refuses the push
        for (int i = 0; i < D; i++) ekle(32'h400 + 32'(i * 4), 32'h1000 + 32'(i), 0, 32'h0);
        i_ekle = 1; i_buyruk_adresi = 32'h500; i_buyruk = 32'h5; i_buyruk_ongoru = 0;
        i_coz = 1; i_gercek_atladi = 0;
        #1;
        chk("s4_dolu_hazir", {31'd0, o_hazir}, 32'd0);
        tick();
        i_coz = 0;
        i_buyruk_adresi = 32'h600; i_buyruk = 32'h6;
        #1;
        chk("s4_sonra_hazir", {31'd0, o_hazir}, 32'd1);
        tick();
        i_ekle = 0;
        for (int i = 0; i < D; i++) coz(0, 32'h0);
        chk("s4_son_adres", o_eski_buyruk_adresi, 32'h600);
        chk("s4_bos", {31'd0, o_kuyruk_bos}, 32'd1);

        // Resolve while empty alongside an enqueue
        i_coz = 1; i_gercek_atladi = 0;
        ekle(32'h700, 32'h7, 0, 32'h0);
        i_coz = 0;
        chk("s5_hata", {31'd0, o_hata}, 32'd1);
        chk("s5_guncelle", {31'd0, o_guncelle}, 32'd0);
        chk("s5_bos", {31'd0, o_kuyruk_bos}, 32'd0);
        ekle(32'h704, 32'h8, 1, 32'h900);
        ekle(32'h708, 32'h9, 0, 32'h0);
        i_temizle = 1; i_coz = 1; i_gercek_atladi = 1;
        tick();
        i_temizle = 0; i_coz = 0;
        chk("s5_temizle_bos", {31'd0, o_kuyruk_bos}, 32'd1);
        chk("s5_temizle_guncelle", {31'd0, o_guncelle}, 32'd0);
        chk("s5_temizle_yonlendir", {31'd0, o_yonlendir}, 32'd0);

        // Asynchronous reset mid-operation
        ekle(32'h800, 32'hA, 1, 32'h840);
        i_reset = 1;
        #3;
        chk("rst_hazir", {31'd0, o_hazir}, 32'd1);
        chk("rst_bos", {31'd0, o_kuyruk_bos}, 32'd1);
        chk("rst_hata", {31'd0, o_hata}, 32'd0);
        tick();
        i_reset = 0;
        tick();

        // Three resolves, one target mispredict
        ekle(32'hA00, 32'hB, 1, 32'h300);
        coz(1, 32'h300);
        ekle(32'hA04, 32'hC, 0, 32'h0);
        coz(0, 32'h0);
        ekle(32'hA08, 32'hD, 1, 32'h400);
        coz(1, 32'h500);
        chk("s6_yanlis", {31'd0, o_ongoru_yanlis}, 32'd1);
        chk("s6_adres", o_yonlendirme_adresi, 32'h500);
        tick();
`ifdef DALLANMA_SAYAC_EN
        chk("s6_cozulen", o_cozulen_sayisi, 32'd3);
        chk("s6_yanlis_say", o_yanlis_sayisi, 32'd1);
`endif
        repeat (3) tick();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
